// File: rtl/cursor_input_ctrl_pkg.sv
// rtl/cursor_input_ctrl_pkg.sv - shared constants and types for the cursor input front end
package cursor_input_ctrl_pkg;

   localparam int BTN_D = 4;
   localparam int BTN_C = 3;
   localparam int BTN_U = 2;
   localparam int BTN_L = 1;
   localparam int BTN_R = 0;

   localparam int DEFAULT_BOARD_W = 64;
   localparam int DEFAULT_BOARD_H = 64;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } repeat_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cursor_input_ctrl_btn_repeat.sv
// rtl/cursor_input_ctrl_btn_repeat.sv - press/delay/auto-repeat pulse generator for one direction
module btn_repeat
   import cursor_input_ctrl_pkg::*;
#(
   parameter int HOLD_DELAY    = 2**25,
   parameter int REPEAT_PERIOD = 2**22
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clean_i,
   output logic pulse_o
);

   // +1 so the counter can actually reach a power-of-two terminal value
   localparam int CNT_W = $clog2(max_int(HOLD_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] HOLD_CNT   = CNT_W'(HOLD_DELAY);
   localparam logic [CNT_W-1:0] REPEAT_CNT = CNT_W'(REPEAT_PERIOD);

   repeat_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_q, pulse_d;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      if (!clean_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               pulse_d = 1'b1;
               cnt_d   = CNT_ONE;
               state_d = DELAY;
            end
            DELAY: begin
               if (cnt_q == HOLD_CNT) begin
                  pulse_d = 1'b1;
                  cnt_d   = CNT_ONE;
                  state_d = REPEAT;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            REPEAT: begin
               if (cnt_q == REPEAT_CNT) begin
                  pulse_d = 1'b1;
                  cnt_d   = CNT_ONE;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/cursor_input_ctrl.sv
// rtl/cursor_input_ctrl.sv - debounced buttons/switches driving a wrap-or-clamp board cursor
module cursor_input_ctrl
   import cursor_input_ctrl_pkg::*;
#(
   parameter int LOG_DEB       = 20,
   parameter int HOLD_DELAY    = 2**25,
   parameter int REPEAT_PERIOD = 2**22,
   parameter int BOARD_W       = DEFAULT_BOARD_W,
   parameter int BOARD_H       = DEFAULT_BOARD_H,
   parameter int NUM_SW        = 16,
   parameter int SPEED_W       = 4
) (
   input  logic                       clk_in,
   input  logic                       rst_n_in,
   input  logic [4:0]                 btn_in,
   input  logic [NUM_SW-1:0]          sw_in,
   input  logic                       wrap_en_in,
   output logic                       click_out,
   output logic                       click_held_out,
   output logic [SPEED_W-1:0]         speed_out,
   output logic [NUM_SW-1:0]          sw_clean_out,
   output logic [$clog2(BOARD_W)-1:0] cursor_x_out,
   output logic [$clog2(BOARD_H)-1:0] cursor_y_out
);

   localparam int NCH = 5 + NUM_SW;
   localparam int XW  = $clog2(BOARD_W);
   localparam int YW  = $clog2(BOARD_H);
   localparam logic [XW-1:0] X_MAX = XW'(BOARD_W - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(BOARD_H - 1);
   localparam logic [XW-1:0] X_RST = XW'(BOARD_W / 2);
   localparam logic [YW-1:0] Y_RST = YW'(BOARD_H / 2);

   logic [NCH-1:0]     raw;
   logic [NCH-1:0]     sample_q;
   logic [NCH-1:0]     clean_q;
   logic [LOG_DEB-1:0] deb_cnt_q [NCH];

   assign raw = {sw_in, btn_in};

   // Counter saturates at all-ones; clean keeps following sample while it stays there
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         sample_q <= '0;
         clean_q  <= '0;
         for (int i = 0; i < NCH; i++) deb_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (raw[i] != sample_q[i]) begin
               sample_q[i]  <= raw[i];
               deb_cnt_q[i] <= '0;
            end else if (&deb_cnt_q[i]) begin
               clean_q[i] <= sample_q[i];
            end else begin
               deb_cnt_q[i] <= deb_cnt_q[i] + LOG_DEB'(1);
            end
         end
      end
   end

   logic [3:0] dir_clean;
   logic [3:0] move_pulse;

   assign dir_clean = {clean_q[BTN_D], clean_q[BTN_U], clean_q[BTN_L], clean_q[BTN_R]};

   btn_repeat #(
      .HOLD_DELAY   (HOLD_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
   ) u_repeat [3:0] (
      .clk_i  (clk_in),
      .rst_n_i(rst_n_in),
      .clean_i(dir_clean),
      .pulse_o(move_pulse)
   );

   logic [XW-1:0] cur_x_q, cur_x_d;
   logic [YW-1:0] cur_y_q, cur_y_d;
   logic          click_prev_q;
   logic          click_q, click_d;

   always_comb begin
      cur_x_d = cur_x_q;
      cur_y_d = cur_y_q;
      if (move_pulse[0] && !move_pulse[1]) begin
         cur_x_d = (cur_x_q == X_MAX) ? (wrap_en_in ? '0 : X_MAX) : cur_x_q + XW'(1);
      end else if (move_pulse[1] && !move_pulse[0]) begin
         cur_x_d = (cur_x_q == '0) ? (wrap_en_in ? X_MAX : '0) : cur_x_q - XW'(1);
      end
      if (move_pulse[3] && !move_pulse[2]) begin
         cur_y_d = (cur_y_q == Y_MAX) ? (wrap_en_in ? '0 : Y_MAX) : cur_y_q + YW'(1);
      end else if (move_pulse[2] && !move_pulse[3]) begin
         cur_y_d = (cur_y_q == '0) ? (wrap_en_in ? Y_MAX : '0) : cur_y_q - YW'(1);
      end
      click_d = clean_q[BTN_C] & ~click_prev_q;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         cur_x_q      <= X_RST;
         cur_y_q      <= Y_RST;
         click_prev_q <= 1'b0;
         click_q      <= 1'b0;
      end else begin
         cur_x_q      <= cur_x_d;
         cur_y_q      <= cur_y_d;
         click_prev_q <= clean_q[BTN_C];
         click_q      <= click_d;
      end
   end

   assign click_out      = click_q;
   assign click_held_out = clean_q[BTN_C];
   assign speed_out      = clean_q[5 +: SPEED_W];
   assign sw_clean_out   = clean_q[NCH-1:5];
   assign cursor_x_out   = cur_x_q;
   assign cursor_y_out   = cur_y_q;

endmodule
